// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing front end for the 32-bit structural ALU.
//
// Accepts a command on the req_* channel, drives the ALU operands and op code
// from registers, captures the ALU result and flags, and returns them on the
// rsp_* channel. With ALU_SEQ_MUL_EN defined, cmd 5 runs a 32-iteration
// unsigned shift-add multiply that reuses the ALU adder. Without the macro,
// cmd 5 is illegal.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_cmd, req_a, req_b        command (0 AND,1 OR,2 ADD,3 SUB,4 SLT,5 MUL) and operands
//   alu_a, alu_b, alu_op         registered ALU inputs
//   alu_out, alu_zero,
//   alu_overflow, alu_cout       ALU result and flags
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_flags, rsp_err result, {N,Z,V,C}, illegal-command flag
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);

  localparam logic [2:0] CmdAnd = 3'd0;
  localparam logic [2:0] CmdOr  = 3'd1;
  localparam logic [2:0] CmdAdd = 3'd2;
  localparam logic [2:0] CmdSub = 3'd3;
  localparam logic [2:0] CmdSlt = 3'd4;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] CmdMul = 3'd5;
`endif

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
`ifdef ALU_SEQ_MUL_EN
    , StMul
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic        addsub;

`ifdef ALU_SEQ_MUL_EN
  logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_next;
`endif

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;

  // V and C are only meaningful for the arithmetic ops.
  assign addsub = (op_q == OpAdd) || (op_q == OpSub);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    acc_next = mplier_q[0] ? alu_out : acc_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = OpAnd;
          err_d   = 1'b0;
          state_d = StExec;
          case (req_cmd)
            CmdAnd: op_d = OpAnd;
            CmdOr:  op_d = OpOr;
            CmdAdd: op_d = OpAdd;
            CmdSub: op_d = OpSub;
            CmdSlt: op_d = OpSlt;
`ifdef ALU_SEQ_MUL_EN
            CmdMul: begin
              acc_d    = '0;
              mcand_d  = req_a;
              mplier_d = req_b;
              count_d  = '0;
              a_d      = '0;
              b_d      = req_a;
              op_d     = OpAdd;
              state_d  = StMul;
            end
`endif
            default: begin
              err_d   = 1'b1;
              data_d  = '0;
              flags_d = '0;
              state_d = StResp;
            end
          endcase
        end
      end
      StExec: begin
        data_d  = alu_out;
        flags_d = {alu_out[31], alu_zero, addsub & alu_overflow, addsub & alu_cout};
        state_d = StResp;
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        // ALU computes acc + mcand; keep it only when the multiplier bit is set.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        a_d      = acc_next;
        b_d      = mcand_q << 1;
        if (count_q == 5'd31) begin
          data_d  = acc_next;
          flags_d = {acc_next[31], acc_next == 32'd0, 2'b00};
          state_d = StResp;
        end
      end
`endif
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAnd;
      data_q   <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl. A behavioural 32-bit ALU closes the
// loop on the alu_* ports. Directed vectors cover every command; hand-written
// sequences cover back-pressure and reset mid-operation.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zero, alu_overflow, alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_cout     (alu_cout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err)
  );

  // Structural-ALU model: adder always active (op[2] negates b), so cout and
  // overflow carry adder values even for logic ops.
  logic [32:0] m_sum;
  logic [31:0] m_bop;
  always_comb begin
    m_bop        = alu_op[2] ? ~alu_b : alu_b;
    m_sum        = {1'b0, alu_a} + {1'b0, m_bop} + {32'd0, alu_op[2]};
    alu_cout     = m_sum[32];
    alu_overflow = (alu_a[31] == m_bop[31]) && (m_sum[31] != alu_a[31]);
    case (alu_op[1:0])
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      2'b10:   alu_out = m_sum[31:0];
      default: alu_out = {31'd0, m_sum[31] ^ alu_overflow};
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command, wait (bounded) for the response, then handshake it.
  task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] d, output logic [3:0] f,
                        output logic e);
    @(negedge clk);
    check("req_ready at issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    d = rsp_data;
    f = rsp_flags;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic [3:0]  f;
    logic        e;
    bit          seen;

    vecs.push_back('{"and",      3'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 4'b0000, 1'b0, 2});
    vecs.push_back('{"or_mask",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1000, 1'b0, 2});
    vecs.push_back('{"or",       3'd1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000, 1'b0, 2});
    vecs.push_back('{"add_ovf",  3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010, 1'b0, 2});
    vecs.push_back('{"add_cout", 3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101, 1'b0, 2});
    vecs.push_back('{"sub_eq",   3'd3, 32'd5,         32'd5,         32'h0000_0000, 4'b0101, 1'b0, 2});
    vecs.push_back('{"slt_neg",  3'd4, 32'hFFFF_FFFD, 32'd2,         32'h0000_0001, 4'b0000, 1'b0, 2});
    vecs.push_back('{"slt_pos",  3'd4, 32'd2,         32'hFFFF_FFFD, 32'h0000_0000, 4'b0100, 1'b0, 2});
    vecs.push_back('{"sub_brw",  3'd3, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000, 1'b0, 2});
    vecs.push_back('{"sub_ovf",  3'd3, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011, 1'b0, 2});
    vecs.push_back('{"ill7",     3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b0000, 1'b1, 1});
    vecs.push_back('{"add_aft",  3'd2, 32'd40,        32'd2,         32'd42,        4'b0000, 1'b0, 2});
    vecs.push_back('{"ill6",     3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 1'b1, 1});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{"mul_ffff", 3'd5, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0, 33});
    vecs.push_back('{"mul_wrap", 3'd5, 32'h8000_0000, 32'd2,         32'h0000_0000, 4'b0100, 1'b0, 33});
    vecs.push_back('{"mul_b0",   3'd5, 32'h0000_1234, 32'd0,         32'h0000_0000, 4'b0100, 1'b0, 33});
    vecs.push_back('{"mul_small",3'd5, 32'd7,         32'd6,         32'd42,        4'b0000, 1'b0, 33});
`else
    vecs.push_back('{"mul_ill",  3'd5, 32'h0001_0001, 32'h0000_FFFF, 32'h0000_0000, 4'b0000, 1'b1, 1});
`endif

    rst       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = 3'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data",  rsp_data, 32'd0);
    check("rst rsp_flags", {28'd0, rsp_flags}, 32'd0);
    check("rst rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst alu_a",     alu_a, 32'd0);
    check("rst alu_b",     alu_b, 32'd0);
    check("rst alu_op",    {29'd0, alu_op}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].cmd, vecs[i].a, vecs[i].b, lat, d, f, e);
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
      check({vecs[i].name, " data"}, d, vecs[i].data);
      check({vecs[i].name, " flags"}, {28'd0, f}, {28'd0, vecs[i].flags});
      check({vecs[i].name, " err"}, {31'd0, e}, {31'd0, vecs[i].err});
    end

    // Back-pressure: response held for 10 cycles while a request is offered.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'd2;
    req_a     = 32'd2;
    req_b     = 32'd3;
    @(posedge clk);
    #1 req_cmd = 3'd3;
    req_a = 32'hDEAD_BEEF;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("bp rsp_valid seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold valid", {31'd0, rsp_valid}, 32'd1);
      check("bp hold data",  rsp_data, 32'd5);
      check("bp hold flags", {28'd0, rsp_flags}, 32'd0);
      check("bp req_ready",  {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    // req_valid stayed high through the handshake edge; it must not be taken.
    check("bp post req_ready", {31'd0, req_ready}, 32'd1);
    check("bp post rsp_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;

    // Reset during EXEC drops the transaction and clears captured data.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'd2;
    req_a     = 32'd9;
    req_b     = 32'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstexec rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstexec req_ready", {31'd0, req_ready}, 32'd1);
    check("rstexec rsp_data",  rsp_data, 32'd0);
    check("rstexec alu_a",     alu_a, 32'd0);

`ifdef ALU_SEQ_MUL_EN
    // Reset at MUL iteration 15.
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = 3'd5;
    req_a     = 32'd1000;
    req_b     = 32'd77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("mul alu_op", {29'd0, alu_op}, 32'd2);
    check("mul req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmul rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmul req_ready", {31'd0, req_ready}, 32'd1);
    check("rstmul alu_op",    {29'd0, alu_op}, 32'd0);
    check("rstmul alu_b",     alu_b, 32'd0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no rsp after reset", {31'd0, seen}, 32'd0);

    run_op(3'd2, 32'd1, 32'd1, lat, d, f, e);
    check("add11 latency", lat, 2);
    check("add11 data",    d, 32'd2);
    check("add11 flags",   {28'd0, f}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing front end for the 32-bit structural ALU: accepts commands on a valid/ready request channel, drives the ALU's `a`/`b`/`op` inputs from registered operands, and captures `out`/`zero`/`overflow`/`cout`. It returns result and flags on a valid/ready response channel. It also runs a multi-cycle unsigned shift-add multiply by reusing the ALU adder, so the datapath needs no separate multiplier.

## Interface
Parameters:
- none (datapath fixed at 32 bits to match the ALU)

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_cmd` in 3: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6/7 illegal.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `alu_a` out 32: ALU operand A (registered).
- `alu_b` out 32: ALU operand B (registered).
- `alu_op` out 3: ALU op code (registered); AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- `alu_out` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `alu_overflow` in 1: ALU overflow flag.
- `alu_cout` in 1: ALU carry-out.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes response.
- `rsp_data` out 32: result.
- `rsp_flags` out 4: {N, Z, V, C}.
- `rsp_err` out 1: illegal command.

## Operation
- States: IDLE, EXEC, MUL, RESP.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, load `alu_a=req_a`, `alu_b=req_b`, `alu_op` per the encoding.
  - cmd 0–4 → EXEC.
  - cmd 5 → MUL: acc=0, mcand=`req_a`, mplier=`req_b`, count=0; drive `alu_a`=acc, `alu_b`=mcand, `alu_op`=010.
  - cmd 6/7 → RESP with `rsp_err=1`, data 0, flags 0.
- **EXEC** (one cycle), then → RESP. Capture:
  - `rsp_data=alu_out`
  - N=`alu_out[31]`
  - Z=`alu_zero`
  - V=`alu_overflow`, C=`alu_cout` for ADD/SUB only; V=C=0 for AND/OR/SLT.
- **MUL** (one cycle per iteration):
  - Update: if mplier[0], acc←`alu_out`; then mcand←mcand<<1, mplier←mplier>>1, count++.
  - `alu_a`/`alu_b` follow acc/mcand each cycle; `alu_op` stays 010.
  - After the 32nd iteration → RESP.
  - `rsp_data`=low 32 bits of the product; V=C=0; N=bit31; Z=(result==0), computed locally rather than from `alu_zero`.
- **RESP**
  - `rsp_valid=1`; data, flags and err held stable until `rsp_valid&&rsp_ready`, then → IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Request fields are ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_flags=0`, `rsp_err=0`.
  - `alu_a=0`, `alu_b=0`, `alu_op=000`.
  - acc, mcand, mplier, count = 0.
- Latency, accept edge → first cycle with `rsp_valid` high:
  - Illegal command: 1 cycle.
  - cmd 0–4: 2 cycles (ALU settles during EXEC, sampled at the EXEC-ending edge).
  - MUL: 33 cycles.
- Throughput:
  - One outstanding command.
  - Back-to-back minimum: 3 cycles per single op with `rsp_ready` tied high.
- Reset mid-operation (`rst` high during EXEC, MUL or RESP): next edge returns all state and outputs to reset values; the transaction is dropped with no response.
- `rst` has priority over every handshake in the same cycle.
- MUL overflow beyond 32 bits is silently discarded.
- Operand `req_b`=0 → 32 iterations still run; result 0, Z=1.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - cmd 5 executes the shift-add multiply.
  - MUL state, acc/mcand/mplier/count registers present.
- `ALU_SEQ_MUL_EN` undefined:
  - MUL state and registers removed.
  - cmd 5 treated as illegal: 1-cycle latency, `rsp_err=1`, data 0, flags 0.

## Test plan
- ADD a=0x7FFFFFFF b=0x00000001 → after 2 cycles `rsp_data`=0x80000000, flags N=1 Z=0 V=1 C=0, err 0.
- SUB a=5 b=5 → data 0x00000000, Z=1 C=1 N=0 V=0; then SLT a=0xFFFFFFFD b=2 → data 0x00000001, V=C=0.
- MUL (macro on):
  - a=0x00010001 b=0x0000FFFF → data 0xFFFFFFFF after 33 cycles, N=1 Z=0.
  - a=0x80000000 b=2 → data 0, Z=1.
- Back-pressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → data/flags stable, `req_ready`=0 throughout; release → handshake, `req_ready`=1 next cycle.
- Reset at MUL iteration 15 → next cycle `rsp_valid`=0, `req_ready`=1, `alu_op`=000, no response ever issued; following ADD 1+1 returns 2.
- cmd 7 → `rsp_err`=1, data 0 after 1 cycle; with macro undefined, cmd 5 gives the same response.
